// File: rtl/serv_q_uart_rx_if.sv
// serv_q_uart_rx_if -- receive FIFO read-side bundle.
//   rd_i    : pop the FIFO head (driven by the consumer)
//   data_o  : FIFO head byte, first-word-fall-through
//   valid_o : FIFO non-empty
//   full_o  : FIFO full
// Modports: slave = receiver side, master = consuming logic.
interface serv_q_uart_rx_if;
  logic       rd_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       full_o;

  modport slave  (input  rd_i, output data_o, output valid_o, output full_o);
  modport master (output rd_i, input  data_o, input  valid_o, input  full_o);
endinterface

// File: rtl/serv_q_uart_rx.sv
// serv_q_uart_rx -- 8N1 receiver for the servant SoC UART line `q`.
// Synchronises the serial input, decodes frames and buffers the received
// bytes in a first-word-fall-through FIFO. Sticky framing/overflow flags.
// Ports:
//   clk, rst_n   : fabric clock, asynchronous active-low reset
//   q_i          : serial line, idle high
//   clr_i        : synchronous clear of both sticky flags
//   frame_err_o  : sticky, stop bit sampled low
//   overflow_o   : sticky, good byte dropped because the FIFO was full
//   fifo_if      : FIFO read side (rd_i, data_o, valid_o, full_o)
module serv_q_uart_rx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   q_i,
  input  logic                   clr_i,
  output logic                   frame_err_o,
  output logic                   overflow_o,
  serv_q_uart_rx_if.slave        fifo_if
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  // Synchroniser and edge history, reset to the idle (high) line level.
  logic sync1_q, q_s_q, q_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      q_s_q    <= 1'b1;
      q_prev_q <= 1'b1;
    end else begin
      sync1_q  <= q_i;
      q_s_q    <= sync1_q;
      q_prev_q <= q_s_q;
    end
  end

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push, ferr_set, tick;

  // Counter is loaded with (wait - 1) and sampling happens when it hits zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    tick     = (cnt_q == '0);
    case (state_q)
      S_IDLE: begin
        if (q_prev_q && !q_s_q) begin
          state_d = S_START;
          cnt_d   = HALF_M1;
        end
      end
      S_START: begin
        if (tick) begin
          if (!q_s_q) begin
            state_d = S_DATA;
            cnt_d   = FULL_M1;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d[idx_q] = q_s_q;
          cnt_d          = FULL_M1;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (tick) begin
          if (q_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BREAK: begin
        if (q_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // FIFO: AW+1 bit pointers, full when only the MSBs differ.
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        empty, full, pop, wr, ovf_set;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop     = fifo_if.rd_i && !empty;
  assign wr      = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr) begin
        mem_q[wptr_q[AW-1:0]] <= shift_q;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
    end
  end

  assign fifo_if.data_o  = mem_q[rptr_q[AW-1:0]];
  assign fifo_if.valid_o = !empty;
  assign fifo_if.full_o  = full;

  // Sticky flags: a set event in the same cycle as clr_i wins.
  logic ferr_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (ferr_set)   ferr_q <= 1'b1;
      else if (clr_i) ferr_q <= 1'b0;
      if (ovf_set)    ovf_q  <= 1'b1;
      else if (clr_i) ovf_q  <= 1'b0;
    end
  end

  assign frame_err_o = ferr_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_serv_q_uart_rx.sv
// tb_serv_q_uart_rx -- scoreboard bench for serv_q_uart_rx (8 clocks/bit, depth 4).
module tb_serv_q_uart_rx;
  logic clk = 1'b0;
  logic rst_n, q_i, clr_i;
  logic frame_err_o, overflow_o;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] exp_q [$];

  serv_q_uart_rx_if u_if ();

  serv_q_uart_rx #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .q_i         (q_i),
    .clr_i       (clr_i),
    .frame_err_o (frame_err_o),
    .overflow_o  (overflow_o),
    .fifo_if     (u_if)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted pop is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && u_if.rd_i && u_if.valid_o) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL pop_unexpected: got %02h, required no byte", u_if.data_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (u_if.data_o !== e) begin
          n_errors++;
          $display("FAIL pop_data: got %02h, required %02h", u_if.data_o, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pop();
    u_if.rd_i = 1'b1;
    idle(1);
    u_if.rd_i = 1'b0;
  endtask

  // Start bit, 8 data bits LSB first, then the stop bit (8 clocks each).
  // The stop sample lands on the 7th edge of the stop bit; pop_at_stop
  // raises rd_i in exactly that cycle, chk_lat checks valid_o around it.
  task automatic send_frame(input logic [7:0] b, input logic stop_val,
                            input bit pop_at_stop, input bit chk_lat);
    q_i = 1'b0;
    idle(8);
    for (int k = 0; k < 8; k++) begin
      q_i = b[k];
      idle(8);
    end
    q_i = stop_val;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (pop_at_stop) u_if.rd_i = (i == 5);
      if (chk_lat && i == 5) check("push_lat_before", u_if.valid_o, 1'b0);
      if (chk_lat && i == 6) check("push_lat_after", u_if.valid_o, 1'b1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    q_i       = 1'b1;
    clr_i     = 1'b0;
    u_if.rd_i = 1'b0;
    idle(3);
    check("rst_valid", u_if.valid_o, 1'b0);
    check("rst_full", u_if.full_o, 1'b0);
    check("rst_data", u_if.data_o, 8'h00);
    check("rst_ferr", frame_err_o, 1'b0);
    check("rst_ovf", overflow_o, 1'b0);
    rst_n = 1'b1;
    idle(5);

    // Two back-to-back frames
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hA3);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("b2b_valid", u_if.valid_o, 1'b1);
    check("b2b_head", u_if.data_o, 8'h55);
    pop();
    check("b2b_second", u_if.data_o, 8'hA3);
    pop();
    check("b2b_empty", u_if.valid_o, 1'b0);
    check("b2b_ferr", frame_err_o, 1'b0);
    check("b2b_ovf", overflow_o, 1'b0);

    // Glitch on an idle line
    q_i = 1'b0;
    idle(2);
    q_i = 1'b1;
    idle(30);
    check("glitch_valid", u_if.valid_o, 1'b0);
    check("glitch_ferr", frame_err_o, 1'b0);

    // Frame error followed by a held-low break
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(10);
    check("ferr_set", frame_err_o, 1'b1);
    check("ferr_nopush", u_if.valid_o, 1'b0);
    clr_i = 1'b1;
    idle(1);
    clr_i = 1'b0;
    check("ferr_clr", frame_err_o, 1'b0);
    idle(30);
    q_i = 1'b1;
    idle(20);
    check("break_one_err", frame_err_o, 1'b0);
    check("break_nobyte", u_if.valid_o, 1'b0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("after_break_valid", u_if.valid_o, 1'b1);
    pop();

    // Overflow: five bytes into four entries
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    idle(2);
    check("ovf_full", u_if.full_o, 1'b1);
    check("ovf_flag", overflow_o, 1'b1);
    for (int i = 0; i < 4; i++) pop();
    check("ovf_drained", u_if.valid_o, 1'b0);
    check("ovf_notfull", u_if.full_o, 1'b0);
    clr_i = 1'b1;
    idle(1);
    clr_i = 1'b0;
    check("ovf_clr", overflow_o, 1'b0);

    // Push and pop in the same cycle while full
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
    idle(2);
    check("pp_full", u_if.full_o, 1'b1);
    exp_q.push_back(8'h14);
    send_frame(8'h14, 1'b1, 1'b1, 1'b0);
    idle(2);
    check("pp_no_ovf", overflow_o, 1'b0);
    check("pp_still_full", u_if.full_o, 1'b1);
    for (int i = 0; i < 4; i++) pop();
    check("pp_empty", u_if.valid_o, 1'b0);

    // Reset mid-frame, with a stale byte in the FIFO that reset must discard
    send_frame(8'h33, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("rmf_stale", u_if.valid_o, 1'b1);
    q_i = 1'b0;
    idle(8);
    q_i = 1'b1;
    idle(32);
    rst_n = 1'b0;
    idle(2);
    check("rmf_in_reset", u_if.valid_o, 1'b0);
    rst_n = 1'b1;
    idle(20);
    check("rmf_valid", u_if.valid_o, 1'b0);
    check("rmf_ferr", frame_err_o, 1'b0);
    check("rmf_ovf", overflow_o, 1'b0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("rmf_rx_valid", u_if.valid_o, 1'b1);
    pop();
    check("rmf_final_empty", u_if.valid_o, 1'b0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
